mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the MIPS datapath. Sits directly downstream of the register file.
- Consumes the two register read ports (rs, rt values) and executes MULT/MULTU/DIV/DIVU over multiple cycles.
- Holds the architectural HI/LO registers. Controller stalls on busy; MFHI/MFLO read hi/lo; MTHI/MTLO write them.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  launch operation; sampled only when busy=0
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  32  operand A / dividend (register read data 1)
- rt_val  in  32  operand B / divisor (register read data 2)
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wd  in  32  MTHI/MTLO write data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, hi/lo just updated by an operation
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset: asynchronous on rst_n=0. hi=0, lo=0, busy=0, done=0, counter=0, internal regs=0. Reset mid-operation aborts the operation; no partial result reaches hi/lo.
- Accept: at edge N with start=1 and busy=0, latch op.
  - Signed ops latch the absolute values of both operands and record the sign of the result and of the dividend.
  - Unsigned ops latch raw values.
  - Set counter=XLEN and busy=1.
- start while busy=1: ignored, no side effects.
- Multiply: shift-add, one bit per cycle, 64-bit accumulator.
- Divide: restoring, one quotient bit per cycle, 33-bit partial remainder.
- Latency: counter decrements each edge while busy. At edge N+32 the counter reaches 0:
  - Sign fix-up is applied: negate product if operand signs differ; negate quotient if signs differ; remainder takes the dividend sign.
  - hi/lo written: product hi/lo; divide HI=remainder, LO=quotient.
  - busy=0, done=1.
  - done clears at edge N+33 unless another completion occurs.
- busy is high for exactly 32 cycles. hi/lo keep their prior values until the completion edge.
- Back-to-back: start may be accepted on the cycle done=1 (busy=0). The earliest next accept is edge N+33.
- Divide by zero (rt_val=0, any divide op): full latency; HI=rs_val (original, unsigned view), LO=0xFFFFFFFF.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- hi_we/lo_we:
  - When busy=0: write wd at the edge.
  - When busy=1: ignored.
  - Same edge as start accept: write applies and the operation starts; completion later overwrites both.
  - hi_we and lo_we together both write wd.
- All arithmetic is modulo 2^32 per output; 0x80000000 abs stays 0x80000000 treated as unsigned 2^31.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined:
  - MULT/MULTU complete in one cycle via a combinational 64-bit multiply. hi/lo are written at the accept edge N.
  - busy stays 0; done=1 during the cycle after N.
  - DIV/DIVU unchanged.
- Undefined: all ops iterative as above.

Test Plan:
- Reset then MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy high 32 cycles; at completion HI=0xFFFFFFFE, LO=0x00000001, done single-cycle pulse.
- MULT rs=0xFFFFFFFD (-3) rt=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV rs=0xFFFFFFF9 (-7) rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU rs=0x64 rt=0 -> HI=0x00000064, LO=0xFFFFFFFF after 32 cycles. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- During DIVU 100/7, pulse start (MULTU 2*3) and hi_we (wd=0xDEADBEEF) at cycle 10 -> both ignored; final HI=2, LO=14; busy remains exactly 32 cycles.
- MTLO wd=0x12345678 while idle -> lo=0x12345678 next edge. Start MULT, assert rst_n=0 at cycle 15 -> hi=lo=0, busy=0, done=0 immediately, no later done.
- With MDU_FAST_MUL_EN: MULTU 0x10000 * 0x10000 -> HI=1, LO=0 at accept edge; busy never asserts; done pulses next cycle.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// Define MDU_FAST_MUL_EN to complete MULT/MULTU in a single cycle; DIV/DIVU stay iterative.
module mdu_iter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs_val_i,
  input  logic [XLEN-1:0] rt_val_i,
  input  logic            hi_we_i,
  input  logic            lo_we_i,
  input  logic [XLEN-1:0] wd_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_div_q, is_div_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                dz_q, dz_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;
  logic                done_q, done_d;

  logic                is_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_abs, b_abs;
  logic [XLEN:0]       msum;
  logic [2*XLEN-1:0]   mul_next, div_next;
  logic [XLEN:0]       dshift;
  logic [XLEN-1:0]     ddiff, rem_n;
  logic                ge;

  assign is_signed = ~op_i[0];
  assign a_neg     = is_signed & rs_val_i[XLEN-1];
  assign b_neg     = is_signed & rt_val_i[XLEN-1];
  // 0x80000000 negates to itself, which is the correct unsigned magnitude 2^31.
  assign a_abs     = a_neg ? -rs_val_i : rs_val_i;
  assign b_abs     = b_neg ? -rt_val_i : rt_val_i;

  // Multiply: upper half accumulates, lower half holds the remaining multiplier bits.
  assign msum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
  assign mul_next = acc_q[0] ? {msum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

  // Restoring divide: upper half is the remainder, lower half shifts dividend out, quotient in.
  assign dshift   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign ge       = dshift >= {1'b0, b_q};
  assign ddiff    = dshift[XLEN-1:0] - b_q;
  assign rem_n    = ge ? ddiff : dshift[XLEN-1:0];
  assign div_next = {rem_n, acc_q[XLEN-2:0], ge};

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;
  // Product of sign/zero-extended operands is exact modulo 2^64 for both MULT and MULTU.
  assign ext_a     = {{XLEN{is_signed & rs_val_i[XLEN-1]}}, rs_val_i};
  assign ext_b     = {{XLEN{is_signed & rt_val_i[XLEN-1]}}, rt_val_i};
  assign fast_prod = ext_a * ext_b;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    b_d       = b_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hi_we_i) hi_d = wd_i;
        if (lo_we_i) lo_d = wd_i;
`ifdef MDU_FAST_MUL_EN
        if (start_i && !op_i[1]) begin
          hi_d   = fast_prod[2*XLEN-1:XLEN];
          lo_d   = fast_prod[XLEN-1:0];
          done_d = 1'b1;
        end else
`endif
        if (start_i) begin
          is_div_d  = op_i[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = (rt_val_i == '0);
          b_d       = op_i[1] ? b_abs : a_abs;
          acc_d     = {{XLEN{1'b0}}, (op_i[1] ? a_abs : b_abs)};
          cnt_d     = CNT_W'(XLEN);
          state_d   = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_q - CNT_W'(1);
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == CNT_W'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
          if (is_div_q) begin
            hi_d = neg_rem_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
            lo_d = dz_q ? '1 : (neg_res_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0]);
          end else begin
            {hi_d, lo_d} = neg_res_q ? -acc_d : acc_d;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      b_q       <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy_o = (state_q == StRun);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: vector table driven through a HI/LO scoreboard,
// plus hand sequences for busy-ignore, MTHI/MTLO and reset mid-operation.
module tb_mdu_iter;

`ifdef MDU_FAST_MUL_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wd = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  mdu_iter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .op_i     (op),
    .rs_val_i (rs),
    .rt_val_i (rt),
    .hi_we_i  (hi_we),
    .lo_we_i  (lo_we),
    .wd_i     (wd),
    .busy_o   (busy),
    .done_o   (done),
    .hi_o     (hi),
    .lo_o     (lo)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] sb[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] o);
    return (Fast && !o[1]) ? 0 : 32;
  endfunction

  // Launch one op; optionally inject start+MTHI at busy cycle inj (0 = none).
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int inj);
    int          lat;
    int          elat;
    logic [63:0] prev;
    logic [63:0] exp;
    @(negedge clk);
    prev  = {hi, lo};
    op    = o;
    rs    = a;
    rt    = b;
    start = 1'b1;
    sb.push_back({eh, el});
    @(posedge clk);
    #1;
    start = 1'b0;
    elat  = exp_lat(o);
    if (elat != 0) begin
      check({name, " busy@accept"}, 64'(busy), 64'd1);
      check({name, " done@accept"}, 64'(done), 64'd0);
    end
    lat = 0;
    while (busy && lat < 100) begin
      if (inj > 0 && lat == inj) begin
        start = 1'b1;
        op    = 2'b01;
        rs    = 32'd2;
        rt    = 32'd3;
        hi_we = 1'b1;
        wd    = 32'hDEADBEEF;
      end
      if (lat == 16) check({name, " hi/lo held"}, {hi, lo}, prev);
      @(posedge clk);
      #1;
      start = 1'b0;
      hi_we = 1'b0;
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(elat));
    check({name, " done"}, 64'(done), 64'd1);
    if (sb.size() == 0) begin
      check({name, " scoreboard empty"}, 64'd1, 64'd0);
    end else begin
      exp = sb.pop_front();
      check({name, " hi:lo"}, {hi, lo}, exp);
    end
  endtask

  initial begin
    int seen_done;

    vecs.push_back('{"multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{"mult_m3x7",  2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB});
    vecs.push_back('{"div_m7d2",   2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"divu_dz",    2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF});
    vecs.push_back('{"div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
    vecs.push_back('{"div_7dm2",   2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
    vecs.push_back('{"div_dz_neg", 2'b10, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF});
    vecs.push_back('{"mult_minsq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    vecs.push_back('{"multu_2p16", 2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000});
    vecs.push_back('{"mult_m1m1",  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001});
    vecs.push_back('{"mult_zero",  2'b00, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000});
    vecs.push_back('{"divu_by1",   2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF});
    vecs.push_back('{"divu_big",   2'b11, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF});

    repeat (2) @(posedge clk);
    #1;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    rst_n = 1'b1;

    // Each op is launched in the done cycle of the previous one (back-to-back).
    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                             vecs[i].eh, vecs[i].el, 0);

    @(posedge clk);
    #1;
    check("done clears", 64'(done), 64'd0);

    run_op("divu_100_7_inject", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    @(posedge clk);
    #1;
    check("no spurious done", 64'(done), 64'd0);
    check("no spurious busy", 64'(busy), 64'd0);

    @(negedge clk);
    lo_we = 1'b1;
    wd    = 32'h12345678;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    check("mtlo lo", 64'(lo), 64'h12345678);
    check("mtlo hi kept", 64'(hi), 64'd2);

    @(negedge clk);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wd    = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mthi+mtlo", {hi, lo}, 64'hA5A5A5A5_A5A5A5A5);

    // Reset 15 cycles into an iterative op: everything clears, no late completion.
    @(negedge clk);
    op    = Fast ? 2'b10 : 2'b00;
    rs    = 32'hFFFFFFFD;
    rt    = 32'h00000007;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset hi:lo", {hi, lo}, 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    #2;
    rst_n = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    check("no done after reset", 64'(seen_done), 64'd0);
    check("hi:lo after reset", {hi, lo}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
